// File: rtl/divider_pkg.sv
// Widths and the result record shared by pipeline_divider and its downstream capture FIFO,
// so the quotient/tag layout stays matched on both sides.
package divider_pkg;

    localparam int Q_WIDTH   = 8;
    localparam int TAG_WIDTH = 4;

    // One captured divider result: the sequence tag it was issued under plus its quotient.
    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [Q_WIDTH-1:0]   q;
    } result_t;

    // Sequence tags wrap modulo 2**TAG_WIDTH.
    function automatic logic [TAG_WIDTH-1:0] tag_advance(input logic [TAG_WIDTH-1:0] tag);
        return tag + TAG_WIDTH'(1);
    endfunction

    // Build a result record from its parts.
    function automatic result_t make_result(input logic [TAG_WIDTH-1:0] tag,
                                            input logic [Q_WIDTH-1:0]   q);
        result_t r;
        r.tag = tag;
        r.q   = q;
        return r;
    endfunction

endpackage : divider_pkg

// File: rtl/fifo_regfile.sv
// Storage for the result FIFO: DEPTH result records, one synchronous write port and one
// combinational read port so the head entry is visible without a read cycle (show-ahead).
module fifo_regfile
    import divider_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  result_t          wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output result_t          rd_data
);

    // Entries hold data only; validity is tracked by the owner's count, so no reset here.
    result_t mem_q [DEPTH];

    // Write the addressed entry when a push is accepted.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : fifo_regfile

// File: rtl/divider_result_fifo.sv
// Capture stage behind pipeline_divider. Every in_valid result is tagged with a running
// sequence number and queued in a show-ahead FIFO drained with valid/ready. The divider
// cannot be stalled, so a registered stall_req warns upstream early and any result that
// arrives while full is dropped and flagged in the sticky overflow bit.
module divider_result_fifo
    import divider_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SLACK = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [Q_WIDTH-1:0]   in_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Q_WIDTH-1:0]   out_q,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 stall_req,
    output logic                 overflow,
    input  logic                 clear_overflow
);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - SLACK);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 stall_q, stall_d;
    logic                 overflow_q, overflow_d;

    logic    push;
    logic    pop;
    logic    drop;
    result_t head;

    // A pop frees a slot on the same edge, so a full FIFO can still accept while draining.
    assign pop  = ~empty_q & out_ready;
    assign push = in_valid & (~full_q | pop);
    assign drop = in_valid & ~push;

    fifo_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (make_result(tag_q, in_q)),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    // Next-state for pointers, occupancy, tag counter and status flags.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        // Every result consumes a tag, even a dropped one, so losses show as tag gaps.
        tag_d      = in_valid ? tag_advance(tag_q) : tag_q;
        full_d     = (count_d == CNT_FULL);
        empty_d    = (count_d == '0);
        stall_d    = (count_d >= CNT_STALL);
        // A drop on the same edge as a clear request wins so no loss goes unreported.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control state register; reset discards contents and restarts tags at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tag_q      <= tag_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    // Head data is forced to zero while empty so stale storage never leaks out.
    assign out_valid = ~empty_q;
    assign out_q     = empty_q ? '0 : head.q;
    assign out_tag   = empty_q ? '0 : head.tag;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign stall_req = stall_q;
    assign overflow  = overflow_q;

endmodule : divider_result_fifo

// File: tb/tb_divider_result_fifo.sv
// Self-checking bench for divider_result_fifo: a queue-based reference model tracks what
// the FIFO must hold, every cycle's outputs are compared against it, and literal checks
// pin the directed scenarios.
module tb_divider_result_fifo;
    import divider_pkg::*;

    localparam int DEPTH = 8;
    localparam int SLACK = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic [Q_WIDTH-1:0]   in_q = '0;
    logic                 out_ready = 1'b0;
    logic                 clear_overflow = 1'b0;
    logic                 out_valid;
    logic [Q_WIDTH-1:0]   out_q;
    logic [TAG_WIDTH-1:0] out_tag;
    logic [CW-1:0]        count;
    logic                 full, empty, stall_req, overflow;

    divider_result_fifo #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_q           (in_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_q          (out_q),
        .out_tag        (out_tag),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .stall_req      (stall_req),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: plain queue of (tag, q) pairs plus tag counter and sticky flag.
    int m_tags[$];
    int m_qs[$];
    int m_tag = 0;
    int m_ovf = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all();
        int n;
        n = m_tags.size();
        check("out_valid", int'(out_valid), (n > 0) ? 1 : 0);
        check("out_q",     int'(out_q),     (n > 0) ? m_qs[0] : 0);
        check("out_tag",   int'(out_tag),   (n > 0) ? m_tags[0] : 0);
        check("count",     int'(count),     n);
        check("full",      int'(full),      (n == DEPTH) ? 1 : 0);
        check("empty",     int'(empty),     (n == 0) ? 1 : 0);
        check("stall_req", int'(stall_req), (n >= DEPTH - SLACK) ? 1 : 0);
        check("overflow",  int'(overflow),  m_ovf);
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic cycle(input bit iv, input int qv, input bit rdy, input bit clr);
        bit pop_m, push_m;
        in_valid       = iv;
        in_q           = Q_WIDTH'(qv);
        out_ready      = rdy;
        clear_overflow = clr;
        pop_m  = (m_tags.size() > 0) && rdy;
        push_m = iv && ((m_tags.size() < DEPTH) || pop_m);
        @(posedge clock);
        if (pop_m) begin
            void'(m_tags.pop_front());
            void'(m_qs.pop_front());
        end
        if (push_m) begin
            m_tags.push_back(m_tag);
            m_qs.push_back(qv % (1 << Q_WIDTH));
        end
        if (iv && !push_m) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (iv) m_tag = (m_tag + 1) % (1 << TAG_WIDTH);
        #1;
        $display("[TB] cyc iv=%0d q=%0d rdy=%0d clr=%0d -> valid=%0d q=%0d tag=%0d cnt=%0d ovf=%0d",
                 iv, qv, rdy, clr, out_valid, out_q, out_tag, count, overflow);
        check_all();
    endtask

    // Asynchronous reset away from the clock edge; effects must be visible immediately.
    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        #2 reset = 1'b1;
        #1;
        m_tags.delete(); m_qs.delete(); m_tag = 0; m_ovf = 0;
        check("rst_empty",     int'(empty), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count",     int'(count), 0);
        check_all();
        @(posedge clock);
        #3 reset = 1'b0;
        #1 check_all();
    endtask

    initial begin
        #1;
        do_reset();

        // Three results held, then drained in order.
        cycle(1, 12, 0, 0);
        cycle(1, 52, 0, 0);
        cycle(1, 93, 0, 0);
        check("s1_count", int'(count), 3);
        check("s1_q0",    int'(out_q), 12);
        check("s1_tag0",  int'(out_tag), 0);
        cycle(0, 0, 1, 0);
        check("s1_q1",    int'(out_q), 52);
        check("s1_tag1",  int'(out_tag), 1);
        cycle(0, 0, 1, 0);
        check("s1_q2",    int'(out_q), 93);
        check("s1_tag2",  int'(out_tag), 2);
        cycle(0, 0, 1, 0);
        check("s1_empty", int'(empty), 1);

        // Fill to full, overflow on the ninth, drain, observe the tag gap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 20 + i, 0, 0);
            if (i + 1 >= DEPTH - SLACK) check("s2_stall", int'(stall_req), 1);
        end
        check("s2_full", int'(full), 1);
        cycle(1, 7, 0, 0);
        check("s2_ovf",   int'(overflow), 1);
        check("s2_count", int'(count), 8);
        for (int i = 0; i < DEPTH; i++) begin
            check("s2_drain_tag", int'(out_tag), i);
            cycle(0, 0, 1, 0);
        end
        cycle(1, 44, 0, 0);
        check("s2_gap_tag", int'(out_tag), 9);

        // Overflow set and clear in the same cycle: set wins; clear alone next.
        for (int i = 0; i < DEPTH - 1; i++) cycle(1, 60 + i, 0, 0);
        cycle(1, 99, 0, 1);
        check("s3_set_wins", int'(overflow), 1);
        cycle(0, 0, 0, 1);
        check("s3_cleared", int'(overflow), 0);

        // Full with simultaneous push and pop: accepted, count stays, no overflow.
        cycle(1, 77, 1, 0);
        check("s4_count", int'(count), 8);
        check("s4_ovf",   int'(overflow), 0);

        // Continuous push+pop across tag and pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(1, $urandom_range(0, 255), 1, 0);
            check("s5_count", int'(count), 8);
        end

        // Reset with five entries held; first push afterwards restarts at tag 0.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        check("s6_count5", int'(count), 5);
        do_reset();
        cycle(1, 33, 0, 0);
        check("s6_tag0", int'(out_tag), 0);
        check("s6_q",    int'(out_q), 33);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 60), $urandom_range(0, 255),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 8));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule : tb_divider_result_fifo
